// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Memory bus between the control unit / datapath (master) and the memory
//   responder (slave).
//   Request side (master -> slave):
//     ram_read   read request level
//     ram_write  write request level
//     addr       word address (low MAR bits)
//     wdata      write data (MDR contents)
//   Response side (slave -> master):
//     rdata      registered read data
//     mem_ready  access complete, held until the request drops
//     mem_busy   access in progress (waiting or accessing)
//     mem_err    illegal request, valid while mem_ready is high
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  ram_read;
  logic                  ram_write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  mem_ready;
  logic                  mem_busy;
  logic                  mem_err;

  modport master (
    output ram_read, ram_write, addr, wdata,
    input  rdata, mem_ready, mem_busy, mem_err
  );

  modport slave (
    input  ram_read, ram_write, addr, wdata,
    output rdata, mem_ready, mem_busy, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Single-port word memory that answers CPU memory requests with a
//   four-phase request/ready handshake and a fixed number of wait states.
//   One request is served at a time; the request is latched when first seen,
//   so later input changes do not disturb an access in flight.
//   Ports:
//     Clock  system clock, rising edge
//     Reset  synchronous, active-high; aborts any access in flight
//     bus    mem_responder_if slave modport (request in, response out)
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic            Clock,
  input  logic            Reset,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_wr_q, op_wr_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem_arr [DEPTH];

  logic             req;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             mem_we;
  logic             rd_en;

  assign req      = bus.ram_read | bus.ram_write;
  assign in_range = {1'b0, addr_q} < DEPTH_L;
  assign idx      = addr_q[IDX_W-1:0];
  // Reset on the same edge as the access cancels it: no write lands.
  assign mem_we   = (state_q == S_ACCESS) && op_wr_q && in_range && !Reset;
  assign rd_en    = (state_q == S_ACCESS) && !op_wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          op_wr_d = bus.ram_write;
          if (bus.ram_read && bus.ram_write) begin
            // Conflicting request: answer immediately, touch nothing.
            state_d = S_DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
            busy_d  = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
            busy_d  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        err_d   = !in_range;
      end
      S_DONE: begin
        // Hold ready until the master drops its request.
        if (!req) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem_arr[idx] <= wdata_q;
    end
  end

  // Registered read port; an out-of-range read returns zero.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= in_range ? mem_arr[idx] : '0;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_busy  = busy_q;
  assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Drives three responders (WAIT_STATES 0, 1, 3; DEPTH 256, ADDR_WIDTH 9)
//   with identical stimulus and checks latency, busy time, read data and the
//   error flag of each against a table of expected results.
module tb_mem_responder;

  localparam int NDUT = 3;
  localparam int WS_TAB [NDUT] = '{0, 1, 3};

  logic        clk;
  logic        rst;
  logic        ram_read;
  logic        ram_write;
  logic [8:0]  addr;
  logic [31:0] wdata;

  logic [31:0] rdata_a [NDUT];
  logic        ready_a [NDUT];
  logic        busy_a  [NDUT];
  logic        err_a   [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus ();
      assign bus.ram_read  = ram_read;
      assign bus.ram_write = ram_write;
      assign bus.addr      = addr;
      assign bus.wdata     = wdata;
      assign rdata_a[gi]   = bus.rdata;
      assign ready_a[gi]   = bus.mem_ready;
      assign busy_a[gi]    = bus.mem_busy;
      assign err_a[gi]     = bus.mem_err;

      mem_responder #(
        .ADDR_WIDTH (9),
        .DATA_WIDTH (32),
        .DEPTH      (256),
        .WAIT_STATES(WS_TAB[gi])
      ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus.slave)
      );
    end
  endgenerate

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          bad;
  } exp_t;

  exp_t sb_q [$];
  int   txn_no = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request (caller is just after a negedge), wait for every DUT to
  // complete, compare against the scoreboard, then finish the handshake.
  task automatic do_req(input logic rd, input logic wr, input logic [8:0] a,
                        input logic [31:0] d, input logic [31:0] er,
                        input logic ee, input bit early_drop);
    exp_t        e;
    int          lat   [NDUT];
    int          busy  [NDUT];
    logic [31:0] rd_s  [NDUT];
    logic        err_s [NDUT];
    bit          all_done;
    int          n;
    e.rdata = er;
    e.err   = ee;
    e.bad   = rd & wr;
    sb_q.push_back(e);
    ram_read  = rd;
    ram_write = wr;
    addr      = a;
    wdata     = d;
    for (int i = 0; i < NDUT; i++) begin
      lat[i] = 0; busy[i] = 0; rd_s[i] = '0; err_s[i] = 1'b0;
    end
    n = 0;
    all_done = 1'b0;
    while (!all_done && n < 30) begin
      @(negedge clk);
      n++;
      if (early_drop && n == 1) begin
        ram_read  = 1'b0;
        ram_write = 1'b0;
      end
      all_done = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
        if (lat[i] == 0) begin
          if (busy_a[i]) busy[i]++;
          if (ready_a[i]) begin
            lat[i]   = n;
            rd_s[i]  = rdata_a[i];
            err_s[i] = err_a[i];
          end
        end
        if (lat[i] == 0) all_done = 1'b0;
      end
    end
    e = sb_q.pop_front();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("t%0d_ws%0d_latency", txn_no, WS_TAB[i]), 64'(lat[i]),
          64'(e.bad ? 1 : 2 + WS_TAB[i]));
      chk($sformatf("t%0d_ws%0d_busy_cycles", txn_no, WS_TAB[i]), 64'(busy[i]),
          64'(e.bad ? 0 : 1 + WS_TAB[i]));
      chk($sformatf("t%0d_ws%0d_rdata", txn_no, WS_TAB[i]), 64'(rd_s[i]), 64'(e.rdata));
      chk($sformatf("t%0d_ws%0d_err", txn_no, WS_TAB[i]), 64'(err_s[i]), 64'(e.err));
    end
    $display("txn %0d rd=%b wr=%b addr=0x%03h wdata=0x%08h lat=%0d/%0d/%0d rdata=0x%08h err=%b",
             txn_no, rd, wr, a, d, lat[0], lat[1], lat[2], rd_s[1], err_s[1]);
    ram_read  = 1'b0;
    ram_write = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("t%0d_ws%0d_ready_drop", txn_no, WS_TAB[i]),
          64'({ready_a[i], err_a[i], busy_a[i]}), 64'(0));
    end
    txn_no++;
  endtask

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 9'h000, 32'h12345678, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 9'h05A, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 9'h05A, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 9'h000, 32'h0,        32'h12345678, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 9'h05A, 32'h11111111, 32'h12345678, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 9'h05A, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 9'h0FF, 32'h0BADF00D, 32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 9'h1FF, 32'hAAAA5555, 32'hDEADBEEF, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'h00000000, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 9'h0FF, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 9'h010, 32'h01010101, 32'h0BADF00D, 1'b0};

    rst       = 1'b1;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: all outputs stay low.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        chk($sformatf("idle_c%0d_ws%0d", c, WS_TAB[i]),
            {29'd0, rdata_a[i], ready_a[i], busy_a[i], err_a[i]}, 64'd0);
      end
    end

    for (int v = 0; v < 11; v++) begin
      do_req(vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d,
             vecs[v].exp_rdata, vecs[v].exp_err, 1'b0);
    end

    // Request dropped one edge after capture: access still completes.
    do_req(1'b1, 1'b0, 9'h05A, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

    // Reset in the middle of a write: aborted, old contents survive.
    ram_write = 1'b1;
    addr      = 9'h010;
    wdata     = 32'hCAFEF00D;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("abort_ws%0d_busy", WS_TAB[i]), 64'(busy_a[i]), 64'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    ram_write = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("abort_ws%0d_outputs", WS_TAB[i]),
          {29'd0, rdata_a[i], ready_a[i], busy_a[i], err_a[i]}, 64'd0);
    end
    @(negedge clk);
    do_req(1'b1, 1'b0, 9'h010, 32'h0, 32'h01010101, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
